// File: rtl/iterative_divider.sv
// ---------------------------------------------------------------------------
// iterative_divider
//   Multi-cycle restoring shift-subtract integer divider, one quotient bit
//   per clock, fixed latency of WIDTH+1 cycles from accept to o_done
//   (1 cycle for a zero divisor). Results and the divide-by-zero flag are
//   held until the next completion.
//
//   Optional build macro:
//     DIVIDER_SIGNED_EN - operands are two's complement; quotient truncates
//                         toward zero and the remainder takes the dividend's
//                         sign. Undefined: pure unsigned, no sign logic.
// ---------------------------------------------------------------------------
module iterative_divider #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Iteration registers: shifting dividend, latched divisor, partial
    // remainder, partial quotient and bit counter.
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [CNT_W-1:0] cnt_q;

    // Held results.
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    logic             accept;
    logic             divisor_zero;
    logic             last_iter;

    logic [WIDTH-1:0] dvd_load;
    logic [WIDTH-1:0] dsr_load;

    logic [WIDTH:0]   rem_t;
    logic [WIDTH:0]   rem_diff;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] quo_final;
    logic [WIDTH-1:0] rem_final;

    assign accept       = (state_q == S_IDLE) && i_start;
    assign divisor_zero = (i_divisor == '0);
    assign last_iter    = (cnt_q == LAST_CNT);

`ifdef DIVIDER_SIGNED_EN
    // Sign of the result parts, captured at accept.
    logic quo_neg_q;
    logic rem_neg_q;

    // Magnitudes of the two's complement operands; MIN maps onto itself,
    // which is the correct unsigned magnitude 2**(WIDTH-1).
    always_comb begin
        dvd_load = i_dividend[WIDTH-1] ? (~i_dividend + 1'b1) : i_dividend;
        dsr_load = i_divisor[WIDTH-1]  ? (~i_divisor + 1'b1)  : i_divisor;
    end

    // Sign flags follow the operands on accept and are otherwise held.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else if (accept) begin
            quo_neg_q <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
            rem_neg_q <= i_dividend[WIDTH-1];
        end
    end
`else
    assign dvd_load = i_dividend;
    assign dsr_load = i_divisor;
`endif

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits. The extra top bit keeps the compare
    // exact even when the remainder's MSB is set.
    always_comb begin
        rem_t    = {rem_q, dvd_q[WIDTH-1]};
        rem_diff = rem_t - {1'b0, dsr_q};
        rem_ge   = (rem_t >= {1'b0, dsr_q});
        rem_step = rem_ge ? rem_diff[WIDTH-1:0] : rem_t[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], rem_ge};
    end

    // Final results from the last step, with sign correction when enabled.
    always_comb begin
`ifdef DIVIDER_SIGNED_EN
        quo_final = quo_neg_q ? (~quo_step + 1'b1) : quo_step;
        rem_final = rem_neg_q ? (~rem_step + 1'b1) : rem_step;
`else
        quo_final = quo_step;
        rem_final = rem_step;
`endif
    end

    // State register.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first, so no path through this block infers a latch.
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (i_start) state_d = divisor_zero ? S_DONE : S_CALC;
            S_CALC: if (last_iter) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: busy outside IDLE, done for the single DONE cycle.
    always_comb begin
        o_busy = (state_q != S_IDLE);
        o_done = (state_q == S_DONE);
    end

    // Datapath: load on accept, iterate in CALC, capture results on the
    // final step. Late i_start and operand changes are ignored while busy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dvd_q       <= '0;
            dsr_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else if (accept) begin
            dvd_q <= dvd_load;
            dsr_q <= dsr_load;
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
            if (divisor_zero) begin
                quotient_q  <= '1;
                remainder_q <= i_dividend;
                dbz_q       <= 1'b1;
            end
        end else if (state_q == S_CALC) begin
            dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt_q <= cnt_q + 1'b1;
            if (last_iter) begin
                quotient_q  <= quo_final;
                remainder_q <= rem_final;
                dbz_q       <= 1'b0;
            end
        end
    end

    assign o_quotient    = quotient_q;
    assign o_remainder   = remainder_q;
    assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_iterative_divider.sv
// ---------------------------------------------------------------------------
// tb_iterative_divider
//   Directed, table-driven bench for iterative_divider (WIDTH=32) with
//   hand-written sequences for back-to-back, ignored start and mid-flight
//   reset. Expected values are hand-computed; signed-build entries are
//   selected with DIVIDER_SIGNED_EN.
// ---------------------------------------------------------------------------
module tb_iterative_divider;

    localparam int W = 32;

    logic         i_clk;
    logic         i_rst;
    logic         i_start;
    logic [W-1:0] i_dividend;
    logic [W-1:0] i_divisor;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_quotient;
    logic [W-1:0] o_remainder;
    logic         o_div_by_zero;

    iterative_divider #(.WIDTH(W)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_dividend    (i_dividend),
        .i_divisor     (i_divisor),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_quotient    (o_quotient),
        .o_remainder   (o_remainder),
        .o_div_by_zero (o_div_by_zero)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Free-running cycle count for absolute spacing measurements.
    int cyc_cnt = 0;
    always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
        end
    endtask

    // Issue one request in the next cycle (cycle 0), then watch up to 100
    // cycles for o_done. Returns at the falling edge of the done cycle.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output int lat, output int done_at, output int busy_cycles);
        lat = -1;
        done_at = -1;
        busy_cycles = 0;
        @(posedge i_clk); #1;
        i_start    = 1'b1;
        i_dividend = a;
        i_divisor  = b;
        @(posedge i_clk); #1;
        i_start    = 1'b0;
        i_dividend = ~a;          // must have no effect after acceptance
        i_divisor  = b + 32'd1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge i_clk);
            if (o_busy) busy_cycles++;
            if (o_done) begin
                lat = c;
                done_at = cyc_cnt;
                break;
            end
        end
    endtask

    // Sample cycles [from_c..to_c] (relative numbering continues from the
    // caller's position) and report the first o_done and the done count.
    task automatic watch(input int from_c, input int to_c, output int first_done, output int n_done);
        first_done = -1;
        n_done = 0;
        for (int c = from_c; c <= to_c; c++) begin
            @(negedge i_clk);
            if (o_done) begin
                n_done++;
                if (first_done < 0) first_done = c;
            end
            @(posedge i_clk); #1;
        end
    endtask

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dsr;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } vec_t;

    vec_t vecs[12];

    int lat, done_at, busy_cycles, first_done, n_done, done1;

    initial begin
        i_rst      = 1'b1;
        i_start    = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;

        vecs[0]  = '{32'hFFFF_FFFF, 32'd3,        32'h5555_5555, 32'd0,        1'b0};
        vecs[1]  = '{32'h0000_1234, 32'd0,        32'hFFFF_FFFF, 32'h1234,     1'b1};
        vecs[2]  = '{32'd9,         32'd3,        32'd3,         32'd0,        1'b0};
        vecs[3]  = '{32'd100,       32'd7,        32'd14,        32'd2,        1'b0};
        vecs[4]  = '{32'd0,         32'd5,        32'd0,         32'd0,        1'b0};
        vecs[5]  = '{32'd1000000,   32'd1000,     32'd1000,      32'd0,        1'b0};
        vecs[6]  = '{32'd12345,     32'd100,      32'd123,       32'd45,       1'b0};
        vecs[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,        32'd0,        1'b0};
        vecs[8]  = '{32'h8000_0000, 32'd1,        32'h8000_0000, 32'd0,        1'b0};
`ifdef DIVIDER_SIGNED_EN
        vecs[9]  = '{32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
        vecs[10] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,       1'b0};
        vecs[11] = '{32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,       1'b0};
`else
        vecs[9]  = '{32'hFFFF_FFF9, 32'd2,        32'h7FFF_FFFC, 32'd1,        1'b0};
        vecs[10] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0};
        vecs[11] = '{32'd7,         32'hFFFF_FFFE, 32'd0,        32'd7,        1'b0};
`endif

        // Reset state.
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check("reset_busy", 32'(o_busy), 32'd0);
        check("reset_done", 32'(o_done), 32'd0);
        check("reset_q",    o_quotient,  32'd0);
        check("reset_r",    o_remainder, 32'd0);
        check("reset_dbz",  32'(o_div_by_zero), 32'd0);

        // Table: result, flag, latency, busy every cycle through done, and
        // a one-cycle done pulse followed by IDLE.
        for (int i = 0; i < 12; i++) begin
            run_div(vecs[i].dvd, vecs[i].dsr, lat, done_at, busy_cycles);
            check($sformatf("v%0d_q", i),   o_quotient,  vecs[i].q);
            check($sformatf("v%0d_r", i),   o_remainder, vecs[i].r);
            check($sformatf("v%0d_dbz", i), 32'(o_div_by_zero), 32'(vecs[i].dbz));
            check($sformatf("v%0d_lat", i), 32'(lat), (vecs[i].dsr == '0) ? 32'd1 : 32'd33);
            check($sformatf("v%0d_busy", i), 32'(busy_cycles), (vecs[i].dsr == '0) ? 32'd1 : 32'd33);
            @(negedge i_clk);
            check($sformatf("v%0d_done_after", i), 32'(o_done), 32'd0);
            check($sformatf("v%0d_busy_after", i), 32'(o_busy), 32'd0);
            check($sformatf("v%0d_q_held", i), o_quotient, vecs[i].q);
        end

        // Back-to-back: second start in the first cycle after DONE.
        run_div(32'd28, 32'd4, lat, done1, busy_cycles);
        check("b2b_q1", o_quotient,  32'd7);
        check("b2b_r1", o_remainder, 32'd0);
        run_div(32'd5, 32'd8, lat, done_at, busy_cycles);
        check("b2b_q2", o_quotient,  32'd0);
        check("b2b_r2", o_remainder, 32'd5);
        check("b2b_gap", 32'(done_at - done1), 32'd34);

        // Start while busy is ignored: 100/7 in cycle 0, 50/5 in cycle 5.
        @(posedge i_clk); #1;
        i_start = 1'b1; i_dividend = 32'd100; i_divisor = 32'd7;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (4) @(posedge i_clk);
        #1;
        i_start = 1'b1; i_dividend = 32'd50; i_divisor = 32'd5;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        watch(6, 40, first_done, n_done);
        check("ign_first_done", 32'(first_done), 32'd33);
        check("ign_n_done",     32'(n_done),     32'd1);
        check("ign_q",          o_quotient,      32'd14);
        check("ign_r",          o_remainder,     32'd2);

        // Reset mid-operation: 100/7 in cycle 0, i_rst in cycle 10.
        @(posedge i_clk); #1;
        i_start = 1'b1; i_dividend = 32'd100; i_divisor = 32'd7;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (9) @(posedge i_clk);
        #1 i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_mid_busy", 32'(o_busy), 32'd0);
        check("rst_mid_q",    o_quotient,  32'd0);
        check("rst_mid_r",    o_remainder, 32'd0);
        @(posedge i_clk); #1;
        watch(12, 45, first_done, n_done);
        check("rst_mid_no_done", 32'(n_done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
